uno_seq: RTL and testbench

UNO_SEQ -- requirements
Module: uno_seq

---
 rtl/uno_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_uno_seq.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uno_seq.sv
// uno_seq: command sequencer for a shared MAC / nonlinear PE.
// Issues operand and coefficient beats, then captures the PE result.
module uno_seq #(
  parameter int MAC_BW  = 12,
  parameter int NTERM   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [MAC_BW-1:0]      cmd_x,
  input  logic [MAC_BW-1:0]      cmd_y,
  input  logic [2*MAC_BW-1:0]    cmd_z,
  input  logic                   cmd_last,
  input  logic                   cfg_we,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_op,
  input  logic [$clog2(NTERM):0] cfg_idx,
  input  logic [MAC_BW-1:0]      cfg_data,
  output logic [1:0]             uno_op,
  output logic [MAC_BW-1:0]      uno_x,
  output logic [MAC_BW-1:0]      uno_y,
  output logic [2*MAC_BW-1:0]    uno_z,
  output logic [MAC_BW-1:0]      uno_coeff,
  output logic                   uno_first_cycle,
  output logic                   uno_last_cycle,
  output logic                   uno_acc_en,
  input  logic [2*MAC_BW-1:0]    uno_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2*MAC_BW-1:0]    rsp_data
);

  localparam int IW = $clog2(NTERM) + 1;
  localparam int KW = (IW > 1) ? IW - 1 : 1;
  localparam int CW = $clog2(MAC_LAT + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    MACRUN,
    NLRUN,
    DRAIN,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [MAC_BW-1:0] coef_q [4][NTERM];
  logic [IW-1:0]     nt_q   [4];

  logic [IW-1:0]       k_q, k_d;
  logic [IW-1:0]       ntl_q, ntl_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          uno_op_q, uno_op_d;
  logic [MAC_BW-1:0]   uno_x_q, uno_x_d;
  logic [MAC_BW-1:0]   uno_y_q, uno_y_d;
  logic [2*MAC_BW-1:0] uno_z_q, uno_z_d;
  logic [MAC_BW-1:0]   uno_coeff_q, uno_coeff_d;
  logic                uno_first_q, uno_first_d;
  logic                uno_last_q, uno_last_d;
  logic                uno_acc_q, uno_acc_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2*MAC_BW-1:0] rsp_data_q, rsp_data_d;

  logic              cfg_wr;
  logic [IW-1:0]     nt_wr;
  logic [IW-1:0]     nt_fwd;
  logic [MAC_BW-1:0] coef0_fwd;

  assign cmd_ready = (state_q == IDLE) || (state_q == MACRUN);
  assign cfg_ready = (state_q == IDLE);
  assign cfg_wr    = cfg_we && cfg_ready && (cfg_op != 2'b00);

  // Term count is clamped into 1..NTERM before storage
  always_comb begin
    nt_wr = cfg_data[IW-1:0];
    if (cfg_data == '0) begin
      nt_wr = IW'(1);
    end else if (cfg_data > MAC_BW'(NTERM)) begin
      nt_wr = IW'(NTERM);
    end
  end

  // Same-cycle config write is forwarded to a command being accepted
  always_comb begin
    nt_fwd    = nt_q[cmd_op];
    coef0_fwd = coef_q[cmd_op][0];
    if (cfg_wr && (cfg_op == cmd_op)) begin
      if (cfg_idx == IW'(NTERM)) begin
        nt_fwd = nt_wr;
      end
      if (cfg_idx == '0) begin
        coef0_fwd = cfg_data;
      end
    end
  end

  // Coefficient and term-count table, written only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < 4; o++) begin
        nt_q[o] <= IW'(1);
        for (int i = 0; i < NTERM; i++) begin
          coef_q[o][i] <= '0;
        end
      end
    end else if (cfg_wr) begin
      if (cfg_idx == IW'(NTERM)) begin
        nt_q[cfg_op] <= nt_wr;
      end else if (cfg_idx < IW'(NTERM)) begin
        coef_q[cfg_op][cfg_idx[KW-1:0]] <= cfg_data;
      end
    end
  end

  // Next-state and registered PE / response outputs
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ntl_d       = ntl_q;
    cnt_d       = cnt_q;
    uno_op_d    = uno_op_q;
    uno_x_d     = uno_x_q;
    uno_y_d     = uno_y_q;
    uno_z_d     = uno_z_q;
    uno_coeff_d = uno_coeff_q;
    uno_first_d = 1'b0;
    uno_last_d  = 1'b0;
    uno_acc_d   = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          uno_op_d = cmd_op;
          uno_x_d  = cmd_x;
          uno_y_d  = cmd_y;
          if (cmd_op == 2'b00) begin
            uno_z_d = cmd_z;
            cnt_d   = '0;
            state_d = cmd_last ? DRAIN : MACRUN;
          end else begin
            uno_z_d     = '0;
            uno_coeff_d = coef0_fwd;
            uno_first_d = 1'b1;
            uno_last_d  = (nt_fwd == IW'(1));
            ntl_d       = nt_fwd;
            k_d         = IW'(1);
            state_d     = NLRUN;
          end
        end
      end
      MACRUN: begin
        if (cmd_valid) begin
          uno_op_d  = 2'b00;
          uno_x_d   = cmd_x;
          uno_y_d   = cmd_y;
          uno_acc_d = 1'b1;
          if (cmd_last) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      NLRUN: begin
        if (uno_last_q) begin
          // last term already on the PE; one drain cycle is spent here
          cnt_d   = CW'(1);
          state_d = DRAIN;
        end else begin
          uno_coeff_d = coef_q[uno_op_q][k_q[KW-1:0]];
          uno_last_d  = (k_q == ntl_q - IW'(1));
          k_d         = k_q + IW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(MAC_LAT)) begin
          rsp_data_d  = uno_result;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      ntl_q       <= IW'(1);
      cnt_q       <= '0;
      uno_op_q    <= '0;
      uno_x_q     <= '0;
      uno_y_q     <= '0;
      uno_z_q     <= '0;
      uno_coeff_q <= '0;
      uno_first_q <= 1'b0;
      uno_last_q  <= 1'b0;
      uno_acc_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ntl_q       <= ntl_d;
      cnt_q       <= cnt_d;
      uno_op_q    <= uno_op_d;
      uno_x_q     <= uno_x_d;
      uno_y_q     <= uno_y_d;
      uno_z_q     <= uno_z_d;
      uno_coeff_q <= uno_coeff_d;
      uno_first_q <= uno_first_d;
      uno_last_q  <= uno_last_d;
      uno_acc_q   <= uno_acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign uno_op          = uno_op_q;
  assign uno_x           = uno_x_q;
  assign uno_y           = uno_y_q;
  assign uno_z           = uno_z_q;
  assign uno_coeff       = uno_coeff_q;
  assign uno_first_cycle = uno_first_q;
  assign uno_last_cycle  = uno_last_q;
  assign uno_acc_en      = uno_acc_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;

endmodule

// File: tb/tb_uno_seq.sv
// tb_uno_seq: directed bench for uno_seq with response scoreboard.
// PE result is a cycle stamp so capture timing shows in rsp_data.
module tb_uno_seq;

  localparam logic [23:0] K = 24'h5A5000;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_x;
  logic [11:0] cmd_y;
  logic [23:0] cmd_z;
  logic        cmd_last;
  logic        cfg_we;
  logic        cfg_ready;
  logic [1:0]  cfg_op;
  logic [3:0]  cfg_idx;
  logic [11:0] cfg_data;
  logic [1:0]  uno_op;
  logic [11:0] uno_x;
  logic [11:0] uno_y;
  logic [23:0] uno_z;
  logic [11:0] uno_coeff;
  logic        uno_first_cycle;
  logic        uno_last_cycle;
  logic        uno_acc_en;
  logic [23:0] uno_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [23:0] rsp_data;

  logic [23:0] cyc;
  int total;
  int bad;

  typedef struct {
    logic [23:0] data;
    logic [23:0] vcyc;
  } exp_t;

  exp_t sb[$];

  uno_seq #(
    .MAC_BW(12),
    .NTERM(8),
    .MAC_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_z(cmd_z),
    .cmd_last(cmd_last),
    .cfg_we(cfg_we),
    .cfg_ready(cfg_ready),
    .cfg_op(cfg_op),
    .cfg_idx(cfg_idx),
    .cfg_data(cfg_data),
    .uno_op(uno_op),
    .uno_x(uno_x),
    .uno_y(uno_y),
    .uno_z(uno_z),
    .uno_coeff(uno_coeff),
    .uno_first_cycle(uno_first_cycle),
    .uno_last_cycle(uno_last_cycle),
    .uno_acc_en(uno_acc_en),
    .uno_result(uno_result),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 24'd1;

  assign uno_result = cyc ^ K;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgw(input logic [1:0] op, input logic [3:0] idx,
                      input logic [11:0] d);
    cfg_we   = 1'b1;
    cfg_op   = op;
    cfg_idx  = idx;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    if (!rsp_valid) begin
      total++;
      bad++;
      $display("FAIL %s: rsp_valid timeout got 0 expected 1", nm);
    end
  endtask

  task automatic finish_rsp(input string nm);
    wait_valid(nm);
    chk({nm, "_cmd_ready_busy"}, cmd_ready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({nm, "_rsp_clear"}, rsp_valid, 0);
    chk({nm, "_cmd_ready_idle"}, cmd_ready, 1);
  endtask

  task automatic send_nl(input logic [1:0] op, input logic [11:0] x,
                         input int nt, output logic [23:0] t);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = 12'h045;
    cmd_last  = 1'b0;
    t = cyc;
    sb.push_back('{data: (t + 24'(nt + 1)) ^ K, vcyc: t + 24'(nt + 2)});
    tick();
    cmd_valid = 1'b0;
  endtask

  // Monitor: check each new response against the scoreboard head
  bit seen;
  initial seen = 0;
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (rsp_valid && !seen) begin
      exp_t e;
      seen = 1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got data %0h expected none", rsp_data);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_cycle", cyc, e.vcyc);
      end
    end else if (!rsp_valid) begin
      seen = 0;
    end
  end

  initial begin
    logic [23:0] t;
    logic [23:0] ed;
    total = 0;
    bad = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_x = '0;
    cmd_y = '0;
    cmd_z = '0;
    cmd_last = 1'b0;
    cfg_we = 1'b0;
    cfg_op = '0;
    cfg_idx = '0;
    cfg_data = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_uno_coeff", uno_coeff, 0);
    chk("rst_uno_strobes",
        {uno_first_cycle, uno_last_cycle, uno_acc_en}, 0);
    rst = 1'b0;
    tick();

    // exp with three terms
    cfgw(2'b10, 4'd8, 12'd3);
    cfgw(2'b10, 4'd0, 12'd5);
    cfgw(2'b10, 4'd1, 12'd6);
    cfgw(2'b10, 4'd2, 12'd7);
    chk("exp_cmd_ready", cmd_ready, 1);
    send_nl(2'b10, 12'h123, 3, t);
    chk("exp_k0_coeff", uno_coeff, 5);
    chk("exp_k0_fl", {uno_first_cycle, uno_last_cycle}, 2'b10);
    chk("exp_k0_acc", uno_acc_en, 0);
    chk("exp_k0_op", uno_op, 2'b10);
    chk("exp_k0_x", uno_x, 12'h123);
    chk("exp_k0_z", uno_z, 0);
    chk("exp_nl_cmd_ready", cmd_ready, 0);
    tick();
    chk("exp_k1_coeff", uno_coeff, 6);
    chk("exp_k1_fl", {uno_first_cycle, uno_last_cycle}, 2'b00);
    tick();
    chk("exp_k2_coeff", uno_coeff, 7);
    chk("exp_k2_fl", {uno_first_cycle, uno_last_cycle}, 2'b01);
    tick();
    chk("exp_post_strobes",
        {uno_first_cycle, uno_last_cycle, uno_acc_en}, 0);
    chk("exp_post_coeff_hold", uno_coeff, 7);
    finish_rsp("exp");

    // same-cycle cfg write: nt 4 overridden by nt=0 (stored as 1)
    cfgw(2'b01, 4'd0, 12'h0AB);
    cfgw(2'b01, 4'd8, 12'd4);
    cfg_we = 1'b1;
    cfg_op = 2'b01;
    cfg_idx = 4'd8;
    cfg_data = 12'd0;
    send_nl(2'b01, 12'h011, 1, t);
    cfg_we = 1'b0;
    chk("div_nt1_fl", {uno_first_cycle, uno_last_cycle}, 2'b11);
    chk("div_nt1_coeff", uno_coeff, 12'h0AB);
    tick();
    chk("div_post_strobes", {uno_first_cycle, uno_last_cycle}, 0);
    finish_rsp("div");

    // nt=15 clamps to 8
    cfgw(2'b11, 4'd8, 12'd15);
    cfgw(2'b11, 4'd0, 12'h100);
    cfgw(2'b11, 4'd7, 12'h777);
    send_nl(2'b11, 12'h00F, 8, t);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("log_k%0d_fl", i - 1),
          {uno_first_cycle, uno_last_cycle},
          {1'b0, (i == 1), (i == 8)});
      if (i == 1) chk("log_k0_coeff", uno_coeff, 12'h100);
      if (i == 8) chk("log_k7_coeff", uno_coeff, 12'h777);
      tick();
    end
    chk("log_post_last", uno_last_cycle, 0);
    finish_rsp("log");

    // MAC packet, three back-to-back beats
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_x = 12'd1;
    cmd_y = 12'd4;
    cmd_z = 24'h10;
    cmd_last = 1'b0;
    tick();
    chk("mac_b1_acc", uno_acc_en, 0);
    chk("mac_b1_z", uno_z, 24'h10);
    chk("mac_b1_x", uno_x, 1);
    chk("mac_run_ready", cmd_ready, 1);
    cmd_op = 2'b01;
    cmd_x = 12'd2;
    cmd_y = 12'd5;
    cmd_z = 24'h999;
    tick();
    chk("mac_b2_acc", uno_acc_en, 1);
    chk("mac_b2_z", uno_z, 24'h10);
    chk("mac_b2_op", uno_op, 2'b00);
    cmd_x = 12'd3;
    cmd_y = 12'd6;
    cmd_last = 1'b1;
    t = cyc;
    sb.push_back('{data: (t + 24'd2) ^ K, vcyc: t + 24'd3});
    tick();
    cmd_valid = 1'b0;
    cmd_last = 1'b0;
    chk("mac_b3_acc", uno_acc_en, 1);
    chk("mac_b3_y", uno_y, 6);
    chk("mac_drain_ready", cmd_ready, 0);
    finish_rsp("mac");

    // response held while rsp_ready low; cfg writes dropped
    send_nl(2'b10, 12'h222, 3, t);
    ed = (t + 24'd4) ^ K;
    wait_valid("hold");
    for (int i = 0; i < 10; i++) begin
      cfg_we = 1'b1;
      cfg_op = 2'b10;
      cfg_idx = 4'd0;
      cfg_data = 12'hFFF;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_cfg_ready", cfg_ready, 0);
      tick();
    end
    cfg_we = 1'b0;
    finish_rsp("hold");
    send_nl(2'b10, 12'h333, 3, t);
    chk("hold_cfg_dropped", uno_coeff, 5);
    finish_rsp("hold2");

    // MAC packet with a two-cycle gap
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_x = 12'd7;
    cmd_y = 12'd1;
    cmd_z = 24'h20;
    cmd_last = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("gap_b1_acc", uno_acc_en, 0);
    chk("gap_b1_x", uno_x, 7);
    tick();
    chk("gap_c1_strobes",
        {uno_first_cycle, uno_last_cycle, uno_acc_en}, 0);
    tick();
    chk("gap_c2_strobes",
        {uno_first_cycle, uno_last_cycle, uno_acc_en}, 0);
    chk("gap_x_hold", uno_x, 7);
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    cmd_x = 12'd8;
    tick();
    chk("gap_b2_acc", uno_acc_en, 1);
    chk("gap_b2_op", uno_op, 2'b00);
    chk("gap_b2_z", uno_z, 24'h20);
    cmd_x = 12'd9;
    cmd_last = 1'b1;
    t = cyc;
    sb.push_back('{data: (t + 24'd2) ^ K, vcyc: t + 24'd3});
    tick();
    cmd_valid = 1'b0;
    cmd_last = 1'b0;
    chk("gap_b3_x", uno_x, 9);
    finish_rsp("gap");

    // reset in the middle of a coefficient stream
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_x = 12'h444;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rstmid_k1_coeff", uno_coeff, 6);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_coeff", uno_coeff, 0);
    chk("rstmid_x", uno_x, 0);
    chk("rstmid_op", uno_op, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_cfg_ready", cfg_ready, 1);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("rstmid_no_rsp", rsp_valid, 0);
    send_nl(2'b10, 12'h555, 1, t);
    chk("rstmid_nt_reset", {uno_first_cycle, uno_last_cycle}, 2'b11);
    chk("rstmid_coef_clear", uno_coeff, 0);
    finish_rsp("rstmid");

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
